// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the iterative divider sequencer.
package div_seq_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divider handshake: the EX stage is the master, the divider the slave.
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_for_ex;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_for_ex
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_for_ex
  );
endinterface

// File: rtl/div_seq_ctrl_core.sv
// Radix-2 restoring shift-subtract datapath on unsigned magnitudes: operand
// registers, iteration counter and one iteration per asserted step.
module div_seq_ctrl_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_early,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  logic [2*WIDTH-1:0] part_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;

  // The partial remainder is below the divisor, so trial < 2*divisor and the
  // MSB of a WIDTH+1 wide difference is exactly the borrow.
  always_comb begin
    trial = part_q[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, divisor_q};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      part_q    <= {{WIDTH{1'b0}}, dividend};
      divisor_q <= divisor;
      cnt_q     <= '0;
    end else if (load_early) begin
      part_q    <= {dividend, {WIDTH{1'b0}}};
      divisor_q <= divisor;
      cnt_q     <= CNT_W'(WIDTH);
    end else if (step) begin
      if (diff[WIDTH]) part_q <= {trial[WIDTH-1:0], part_q[WIDTH-2:0], 1'b0};
      else             part_q <= {diff[WIDTH-1:0],  part_q[WIDTH-2:0], 1'b1};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = part_q[WIDTH-1:0];
  assign remainder = part_q[2*WIDTH-1:WIDTH];
  assign done      = (cnt_q == CNT_W'(WIDTH));
endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer for EX: FSM, sign handling, result register, stall request.
// Optional DIV_EARLY_OUT_EN: finish in 2 cycles when |dividend| < |divisor|.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  div_seq_ctrl_if.slave bus
);
  div_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               sign1_q, sign2_q;
  logic               load, load_early, step, done;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   quotient, remainder, q_fix, r_fix;

  assign op1_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign op2_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  div_seq_ctrl_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_early (load_early),
    .step       (step),
    .dividend   (op1_abs),
    .divisor    (op2_abs),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done)
  );

  // Truncating division: quotient sign is the XOR, remainder follows the dividend.
  assign q_fix = (sign1_q ^ sign2_q) ? -quotient : quotient;
  assign r_fix = sign1_q ? -remainder : remainder;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    ready_d    = ready_q;
    load       = 1'b0;
    load_early = 1'b0;
    step       = 1'b0;
    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
`ifdef DIV_EARLY_OUT_EN
            // Counter preset to WIDTH, so ON finishes on its first cycle.
            if (op1_abs < op2_abs) load_early = 1'b1;
            else                   load       = 1'b1;
`else
            load = 1'b1;
`endif
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      DIV_ON: begin
        if (done) begin
          state_d  = DIV_END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DIV_END: begin
        if (!bus.start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = DIV_FREE;
    endcase
    // A flush overrides every state and blocks a start in the same cycle.
    if (bus.annul_i) begin
      state_d    = DIV_FREE;
      result_d   = '0;
      ready_d    = 1'b0;
      load       = 1'b0;
      load_early = 1'b0;
      step       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      result_q <= '0;
      ready_q  <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      if (load || load_early) begin
        sign1_q <= op1_neg;
        sign2_q <= op2_neg;
      end
    end
  end

  assign bus.result_o        = result_q;
  assign bus.ready_o         = ready_q;
  assign bus.stallreq_for_ex = bus.start_i & ~ready_q & ~bus.annul_i;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus randomized divides
// compared against a plain-arithmetic reference model.
module tb_div_seq_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_ctrl_if #(.WIDTH(W)) bus ();
  div_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint to_int(input logic s, input logic [31:0] v);
    if (s) return longint'($signed(v));
    return longint'({32'b0, v});
  endfunction

  function automatic longint mag(input logic s, input logic [31:0] v);
    longint x;
    x = to_int(s, v);
    return (x < 0) ? -x : x;
  endfunction

  // SV integer division truncates toward zero; 64-bit math keeps MIN/-1 exact.
  function automatic logic [63:0] ref_result(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    q = to_int(s, a) / to_int(s, b);
    r = to_int(s, a) % to_int(s, b);
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  function automatic int ref_latency(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(s, a) < mag(s, b)) return 2;
`endif
    return W + 2;
  endfunction

  // Called #1 after a rising edge; returns #1 after a rising edge in IDLE.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int lat, cyc, stall_hi;
    bit got;
    exp = ref_result(s, a, b);
    lat = ref_latency(s, a, b);
    bus.start_i   = 1'b1;
    bus.signed_i  = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    #1;
    stall_hi = bus.stallreq_for_ex ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ready_o) got = 1'b1;
      else if (bus.stallreq_for_ex) stall_hi++;
    end
    check({tag, " ready"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " stall cycles"}, 64'(stall_hi), 64'(lat));
    check({tag, " result"}, bus.result_o, exp);
    check({tag, " stall at ready"}, 64'(bus.stallreq_for_ex), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held result"}, bus.result_o, exp);
      check({tag, " held ready"}, 64'(bus.ready_o), 64'd1);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " idle result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] edge_a [5];
    logic [31:0] edge_b [4];
    logic        s;
    logic [31:0] a, b;
    int          mode;
    edge_a = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
    edge_b = '{32'h1, 32'hFFFF_FFFF, 32'h2, 32'h8000_0000};

    rst = 1'b1;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset stall", 64'(bus.stallreq_for_ex), 64'd0);

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 0);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div("div x/0", 1'b1, 32'd12345, 32'd0, 3);
    run_div("divu x/0", 1'b0, 32'hDEAD_BEEF, 32'd0, 0);
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_div("divu 3/10", 1'b0, 32'd3, 32'd10, 2);

    // Flush in the middle of a divide, then a fresh divide from IDLE.
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    #1;
    check("annul stall masked", 64'(bus.stallreq_for_ex), 64'd0);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("annul ready", 64'(bus.ready_o), 64'd0);
    check("annul result", bus.result_o, 64'd0);
    check("annul stall", 64'(bus.stallreq_for_ex), 64'd0);
    @(posedge clk); #1;
    run_div("post-annul divu", 1'b0, 32'd1000, 32'd3, 0);

    // Asynchronous reset in the middle of a divide.
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd5000;
    bus.opdata2_i = 32'd7;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ready", 64'(bus.ready_o), 64'd0);
    check("async rst result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_div("post-rst divu", 1'b0, 32'hFFFF_FFFF, 32'd16, 0);

    for (int i = 0; i < 24; i++) begin
      s    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 20); b = $urandom_range(1, 50); end
        2: begin a = $urandom; b = 32'd0; end
        default: begin
          a = edge_a[$urandom_range(0, 4)];
          b = edge_b[$urandom_range(0, 3)];
        end
      endcase
      run_div($sformatf("rand%0d", i), s, a, b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
